// File: rtl/adsr_envelope_if.sv
// adsr_envelope_if: note/control bundle between a voice controller and one
// ADSR envelope generator.
//   trigger        one-cycle note-on pulse
//   gate           high while the note is held
//   velocity       note-on velocity, sampled with trigger
//   attack_rate    level increase per tick (1/128 volume LSB)
//   decay_rate     level decrease per tick while decaying
//   sustain_level  sustain as a fraction of velocity (127 = full)
//   release_rate   level decrease per tick while releasing
//   volume         registered envelope output (7-bit)
//   active         envelope not idle
//   env_state      IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
interface adsr_envelope_if;
  logic       trigger;
  logic       gate;
  logic [6:0] velocity;
  logic [6:0] attack_rate;
  logic [6:0] decay_rate;
  logic [6:0] sustain_level;
  logic [6:0] release_rate;
  logic [6:0] volume;
  logic       active;
  logic [2:0] env_state;

  modport master (
    output trigger, gate, velocity, attack_rate, decay_rate, sustain_level, release_rate,
    input  volume, active, env_state
  );

  modport slave (
    input  trigger, gate, velocity, attack_rate, decay_rate, sustain_level, release_rate,
    output volume, active, env_state
  );
endinterface

// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR envelope generator driving a 7-bit voice
// volume. Level is 14-bit 7.7 fixed point and moves on a free-running
// envelope tick every TICK_DIV clocks.
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   bus    adsr_envelope_if.slave (note events, rate controls, outputs)
module adsr_envelope #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic            clk,
  input  logic            reset,
  adsr_envelope_if.slave  bus
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [13:0]   level_q, level_d;
  logic [6:0]    vel_q, vel_d;
  logic [6:0]    volume_q;
  logic [CW-1:0] cnt_q;
  logic          tick;

  logic [13:0]   prod;
  logic [6:0]    sus_frac;
  logic [13:0]   peak;
  logic [13:0]   sus;
  logic [14:0]   attack_sum;
  logic [14:0]   decay_floor;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  // Targets are recomputed every cycle so sustain_level edits apply live.
  always_comb begin
    prod        = 14'(bus.sustain_level) * 14'(vel_q);
    sus_frac    = 7'(prod / 14'd127);
    peak        = {vel_q, 7'b0};
    sus         = {sus_frac, 7'b0};
    attack_sum  = {1'b0, level_q} + {8'b0, bus.attack_rate};
    decay_floor = {1'b0, sus} + {8'b0, bus.decay_rate};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      level_q  <= '0;
      vel_q    <= '0;
      cnt_q    <= '0;
      volume_q <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      vel_q    <= vel_d;
      cnt_q    <= tick ? '0 : cnt_q + CW'(1);
      volume_q <= level_q[13:7];
    end
  end

  // Next-state and level update. A trigger or gate release holds the level
  // for that cycle; arithmetic only happens when the state is kept.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    vel_d   = vel_q;
    if (bus.trigger && bus.velocity != 7'd0) begin
      vel_d   = bus.velocity;
      state_d = ATTACK;
    end else if (bus.trigger) begin
      if (state_q != IDLE) state_d = RELEASE;
    end else if (!bus.gate && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else begin
      unique case (state_q)
        IDLE: level_d = '0;
        ATTACK: begin
          // Compare in 15 bits so level+rate never wraps; also clamps a
          // level left above a lower retrigger peak.
          if (bus.attack_rate == 7'd0 || (tick && attack_sum >= {1'b0, peak})) begin
            level_d = peak;
            state_d = DECAY;
          end else if (tick) begin
            level_d = attack_sum[13:0];
          end
        end
        DECAY: begin
          if (bus.decay_rate == 7'd0 || (tick && {1'b0, level_q} <= decay_floor)) begin
            level_d = sus;
            state_d = SUSTAIN;
          end else if (tick) begin
            level_d = level_q - 14'(bus.decay_rate);
          end
        end
        SUSTAIN: level_d = sus;
        RELEASE: begin
          if (bus.release_rate == 7'd0 || (tick && level_q <= 14'(bus.release_rate))) begin
            level_d = '0;
            state_d = IDLE;
          end else if (tick) begin
            level_d = level_q - 14'(bus.release_rate);
          end
        end
        default: begin
          level_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.volume    = volume_q;
    bus.active    = (state_q != IDLE);
    bus.env_state = state_q;
  end

endmodule
